// File: rtl/col2im_accum.sv
// col2im_accum: inverse of the im2col lowering stage.
//   Reads an im2col-layout matrix of IMG_H*IMG_W rows and IMG_C*FILTER_SIZE^2
//   window elements per row. Each element is scatter-added onto its source
//   pixel, and positions that fall in the zero padding are dropped. The
//   accumulated image is then written back unpadded in CHW order.
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   start      begin a pass (accepted in IDLE and DONE only)
//   data_rd    read data, combinational from addr_rd
//   addr_rd    read address (registered)
//   data_wr    write data (registered)
//   addr_wr    write address (registered)
//   mem_wr_en  write strobe, one element per high cycle
//   done       pass complete, held high in DONE
// Build option: define COL2IM_SAT_EN to clamp written pixels to the signed
//   DATA_WIDTH range instead of truncating them.
module col2im_accum #(
  parameter int IMG_C       = 1,
  parameter int IMG_W       = 8,
  parameter int IMG_H       = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 32,
  parameter int FILTER_SIZE = 3,
  parameter int ACC_WIDTH   = 16,
  parameter logic [ADDR_WIDTH-1:0] IM2COL_BASE = ADDR_WIDTH'('h2000),
  parameter logic [ADDR_WIDTH-1:0] IMG_BASE    = ADDR_WIDTH'('h0000)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data_rd,
  output logic [ADDR_WIDTH-1:0] addr_rd,
  output logic [DATA_WIDTH-1:0] data_wr,
  output logic [ADDR_WIDTH-1:0] addr_wr,
  output logic                  mem_wr_en,
  output logic                  done
);

  localparam int PAD   = (FILTER_SIZE - 1) / 2;
  localparam int N_PIX = IMG_C * IMG_H * IMG_W;
  localparam int IW    = (N_PIX > 1) ? $clog2(N_PIX) : 1;
  localparam int CW    = 16;
  localparam logic [CW-1:0] ROW_MAX = CW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [CW-1:0] CH_MAX  = CW'(IMG_C - 1);
  localparam logic [CW-1:0] FS_MAX  = CW'(FILTER_SIZE - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  state_t state_reg, state_next;

  logic [CW-1:0] row_reg, col_reg, ch_reg, fr_reg, fc_reg;
  logic [IW-1:0] wr_idx_reg;
  logic [ADDR_WIDTH-1:0] addr_rd_reg, addr_wr_reg;
  logic [DATA_WIDTH-1:0] data_wr_reg;
  logic mem_wr_en_reg, done_reg;
  logic signed [ACC_WIDTH-1:0] acc_reg [N_PIX];

  logic start_acc, last_rd, last_wr, hit;
  int ty, tx;
  logic [IW-1:0] tgt_idx, sel_idx;
  logic signed [ACC_WIDTH-1:0] ext, acc_sel;
  logic [DATA_WIDTH-1:0] data_wr_next;

  assign addr_rd   = addr_rd_reg;
  assign addr_wr   = addr_wr_reg;
  assign data_wr   = data_wr_reg;
  assign mem_wr_en = mem_wr_en_reg;
  assign done      = done_reg;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    start_acc  = start && (state_reg == IDLE || state_reg == DONE);
    last_rd    = (row_reg == ROW_MAX) && (col_reg == COL_MAX) && (ch_reg == CH_MAX) &&
                 (fr_reg == FS_MAX) && (fc_reg == FS_MAX);
    last_wr    = (wr_idx_reg == IW'(N_PIX - 1));
    case (state_reg)
      IDLE, DONE: if (start_acc) state_next = READ;
      READ:       if (last_rd)   state_next = WRITE;
      WRITE:      if (last_wr)   state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  // Target pixel of the element currently on data_rd.
  always_comb begin
    ty      = int'(row_reg) + int'(fr_reg) - PAD;
    tx      = int'(col_reg) + int'(fc_reg) - PAD;
    hit     = (state_reg == READ) && (ty >= 0) && (ty < IMG_H) && (tx >= 0) && (tx < IMG_W);
    tgt_idx = IW'((int'(ch_reg) * IMG_H + ty) * IMG_W + tx);
    ext     = ACC_WIDTH'($signed(data_rd));
  end

  // Pixel presented on the next write cycle. On the last read edge the
  // element being accumulated may target pixel 0, so it is forwarded.
  always_comb begin
    sel_idx = (state_reg == READ) ? '0 : wr_idx_reg + 1'b1;
    acc_sel = (int'(sel_idx) < N_PIX) ? acc_reg[sel_idx] : '0;
    if (hit && tgt_idx == sel_idx) acc_sel = acc_sel + ext;
  end

`ifdef COL2IM_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = -ACC_WIDTH'(2 ** (DATA_WIDTH - 1));
  always_comb begin
    data_wr_next = acc_sel[DATA_WIDTH-1:0];
    if (acc_sel > SAT_MAX)      data_wr_next = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (acc_sel < SAT_MIN) data_wr_next = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  end
`else
  logic unused_acc_hi;
  assign unused_acc_hi = ^acc_sel[ACC_WIDTH-1:DATA_WIDTH];
  assign data_wr_next  = acc_sel[DATA_WIDTH-1:0];
`endif

  // One accumulator per output pixel; cleared on reset and when a pass starts.
  generate
    for (genvar gi = 0; gi < N_PIX; gi++) begin : g_acc
      always_ff @(posedge clk) begin
        if (rst || start_acc)                 acc_reg[gi] <= '0;
        else if (hit && tgt_idx == IW'(gi))   acc_reg[gi] <= acc_reg[gi] + ext;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      {row_reg, col_reg, ch_reg, fr_reg, fc_reg} <= '0;
      wr_idx_reg    <= '0;
      addr_rd_reg   <= IM2COL_BASE;
      addr_wr_reg   <= IMG_BASE;
      data_wr_reg   <= '0;
      mem_wr_en_reg <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: if (start_acc) begin
          {row_reg, col_reg, ch_reg, fr_reg, fc_reg} <= '0;
          addr_rd_reg <= IM2COL_BASE;
          addr_wr_reg <= IMG_BASE;
          done_reg    <= 1'b0;
        end
        READ: begin
          addr_rd_reg <= addr_rd_reg + 1'b1;
          // Nested counters, innermost fc.
          if (fc_reg != FS_MAX) fc_reg <= fc_reg + 1'b1;
          else begin
            fc_reg <= '0;
            if (fr_reg != FS_MAX) fr_reg <= fr_reg + 1'b1;
            else begin
              fr_reg <= '0;
              if (ch_reg != CH_MAX) ch_reg <= ch_reg + 1'b1;
              else begin
                ch_reg <= '0;
                if (col_reg != COL_MAX) col_reg <= col_reg + 1'b1;
                else begin
                  col_reg <= '0;
                  row_reg <= row_reg + 1'b1;
                end
              end
            end
          end
          if (last_rd) begin
            mem_wr_en_reg <= 1'b1;
            addr_wr_reg   <= IMG_BASE;
            data_wr_reg   <= data_wr_next;
            wr_idx_reg    <= '0;
          end
        end
        WRITE: begin
          if (last_wr) begin
            mem_wr_en_reg <= 1'b0;
            done_reg      <= 1'b1;
          end else begin
            addr_wr_reg <= addr_wr_reg + 1'b1;
            data_wr_reg <= data_wr_next;
            wr_idx_reg  <= wr_idx_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_col2im_accum.sv
// Testbench for col2im_accum (default parameters: C=1, 8x8, FS=3).
// Expected writes come from a gather-form reference fold of the source
// matrix and are queued before each pass; the write monitor pops and compares.
module tb_col2im_accum;
  localparam int C = 1, W = 8, H = 8, FS = 3, FS2 = 9, P = 1;
  localparam int N_RD = H * W * C * FS2;
  localparam int N_WR = C * H * W;
  localparam logic [31:0] RD_BASE = 32'h2000;
  localparam logic [31:0] WR_BASE = 32'h0000;

  logic clk = 1'b0;
  logic rst, start;
  logic [7:0] data_rd, data_wr;
  logic [31:0] addr_rd, addr_wr;
  logic mem_wr_en, done;

  always #5 clk = ~clk;

  col2im_accum dut (
    .clk(clk), .rst(rst), .start(start), .data_rd(data_rd), .addr_rd(addr_rd),
    .data_wr(data_wr), .addr_wr(addr_wr), .mem_wr_en(mem_wr_en), .done(done)
  );

  logic [7:0] mat [N_RD];
  always_comb begin
    data_rd = 8'h00;
    if (addr_rd >= RD_BASE && addr_rd < RD_BASE + N_RD) data_rd = mat[int'(addr_rd - RD_BASE)];
  end

  typedef struct {logic [31:0] addr; logic [7:0] data;} wr_t;
  wr_t sb[$];

  int n_pass = 0, n_total = 0;
  int cyc = 0, wr_count = 0, first_wr_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Write monitor: one line per write transaction.
  always @(negedge clk) begin
    if (!rst && mem_wr_en) begin
      if (wr_count == 0) first_wr_cyc = cyc;
      wr_count++;
      if (sb.size() == 0) check("unexpected_write", {31'd0, mem_wr_en}, 32'd0);
      else begin
        wr_t e;
        e = sb.pop_front();
        $display("wr addr=%h data=%h exp_addr=%h exp_data=%h", addr_wr, data_wr, e.addr, e.data);
        check("wr_addr", addr_wr, e.addr);
        check("wr_data", {24'd0, data_wr}, {24'd0, e.data});
      end
    end
  end

  function automatic int midx(int row, int col, int ch, int fr, int fc);
    return ((row * W + col) * C + ch) * FS2 + fr * FS + fc;
  endfunction

  // Reference: each output pixel gathers every window element that covers it.
  task automatic push_expected();
    for (int ch = 0; ch < C; ch++)
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++) begin
          int s = 0;
          logic signed [15:0] a;
          logic signed [7:0] e;
          wr_t w;
          for (int fr = 0; fr < FS; fr++)
            for (int fc = 0; fc < FS; fc++) begin
              int row = y - fr + P;
              int col = x - fc + P;
              if (row >= 0 && row < H && col >= 0 && col < W) begin
                e = mat[midx(row, col, ch, fr, fc)];
                s += int'(e);
              end
            end
          a = 16'(s);
`ifdef COL2IM_SAT_EN
          if (a > 16'sd127)       w.data = 8'h7F;
          else if (a < -16'sd128) w.data = 8'h80;
          else                    w.data = a[7:0];
`else
          w.data = a[7:0];
`endif
          w.addr = WR_BASE + 32'(ch * H * W + y * W + x);
          sb.push_back(w);
        end
  endtask

  task automatic fill_const(input logic [7:0] v);
    for (int i = 0; i < N_RD; i++) mat[i] = v;
  endtask

  task automatic fill_ramp();
    for (int row = 0; row < H; row++)
      for (int col = 0; col < W; col++)
        for (int ch = 0; ch < C; ch++)
          for (int fr = 0; fr < FS; fr++)
            for (int fc = 0; fc < FS; fc++) begin
              int y = row + fr - P;
              int x = col + fc - P;
              mat[midx(row, col, ch, fr, fc)] =
                (y >= 0 && y < H && x >= 0 && x < W) ? 8'((y * 8 + x) % 8) : 8'h00;
            end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < N_RD; i++) mat[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_pass(input string tag, input bit glitch);
    int n = 0;
    int t0;
    push_expected();
    wr_count = 0;
    first_wr_cyc = -1;
    pulse_start();
    t0 = cyc;
    while (!done && n < 2000) begin
      @(posedge clk);
      n++;
      #1 start = (glitch && n == 100);
    end
    start = 1'b0;
    $display("pass %s: done after %0d cycles, %0d writes", tag, n, wr_count);
    check({tag, "_done_latency"}, n, N_RD + N_WR);
    check({tag, "_first_write"}, first_wr_cyc - t0, N_RD);
    check({tag, "_write_count"}, wr_count, N_WR);
    check({tag, "_sb_empty"}, sb.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_done_held"}, {31'd0, done}, 32'd1);
    check({tag, "_wr_en_low"}, {31'd0, mem_wr_en}, 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    start = 1'b0;
    fill_const(8'h00);
    repeat (3) @(posedge clk);
    #1;
    check("rst_addr_rd", addr_rd, RD_BASE);
    check("rst_addr_wr", addr_wr, WR_BASE);
    check("rst_data_wr", {24'd0, data_wr}, 32'd0);
    check("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    @(negedge clk) rst = 1'b0;

    fill_const(8'h01);  run_pass("ones", 1'b0);
    fill_ramp();        run_pass("ramp", 1'b0);
    fill_const(8'h64);  run_pass("pos100", 1'b0);
    fill_const(8'h9C);  run_pass("neg100", 1'b0);
    fill_rand();        run_pass("rand_glitch", 1'b1);
    run_pass("rand_again", 1'b0);

    // Reset in the middle of the write phase.
    fill_rand();
    push_expected();
    wr_count = 0;
    pulse_start();
    n = 0;
    while (wr_count < 10 && n < 2000) begin
      @(negedge clk);
      #1 n++;
    end
    check("abort_writes_seen", wr_count, 10);
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    check("abort_wr_en", {31'd0, mem_wr_en}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_addr_wr", addr_wr, WR_BASE);
    check("abort_addr_rd", addr_rd, RD_BASE);
    @(negedge clk) rst = 1'b0;
    wr_count = 0;
    repeat (5) @(posedge clk);
    #1 check("abort_idle_writes", wr_count, 0);
    run_pass("after_abort", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
